// File: rtl/main_gate_truth_table_tester.sv
// main_gate_truth_table_tester
//   Board-side exerciser for a 2-input gate under test. On start it walks
//   {a,b} through 00,01,10,11 and holds each vector SETTLE+1 cycles. In the
//   last held cycle it compares y against the parameter truth table FUNC.
//   It reports pass/fail, a saturating error count and the first bad vector.
//
//   Optional build macro: GATE_TESTER_LOOP_EN
//     undefined : one sweep per start; done is held until the next start/rst.
//     defined   : sweeps repeat until stop. done/pass pulse once per sweep.
//                 err_cnt accumulates across sweeps.
//
// Parameters
//   FUNC   expected y = FUNC[{a,b}], a is the MSB (4'b1000 = AND)
//   SETTLE extra hold cycles per vector before y is sampled (0 allowed)
//   CNT_W  settle counter width, SETTLE < 2**CNT_W
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a sweep; only looked at in IDLE or DONE
//   stop            leave loop mode (loop build only)
//   y               output of the gate under test
//   a, b            gate inputs (a = vector MSB)
//   busy            sweep in progress
//   done, pass      sweep finished / finished with err_cnt == 0
//   err_cnt         mismatching vectors, saturates at 7
//   first_err_vec   {a,b} of the first mismatch, valid with first_err_vld
//   first_err_vld   at least one mismatch seen since the last start
//
// Handshake: start is a level request, not a valid/ready pair. It is
// accepted on any edge where the FSM sits in IDLE or DONE, and is
// ignored while busy. done marks completion and needs no acknowledge.
module main_gate_truth_table_tester #(
  parameter logic [3:0] FUNC   = 4'b1000,
  parameter int         SETTLE = 2,
  parameter int         CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] first_err_vec,
  output logic       first_err_vld
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_cnt_q, err_cnt_d;
  logic [1:0]       first_err_vec_q, first_err_vec_d;
  logic             first_err_vld_q, first_err_vld_d;
  logic             last_cycle;
  logic             mismatch;

`ifdef GATE_TESTER_LOOP_EN
  logic             done_pulse_q, done_pulse_d;
`else
  logic             unused_stop;
  assign unused_stop = stop;
`endif

  // The compare happens only in the final held cycle of a vector, so any
  // glitch on y between compare cycles is invisible.
  assign last_cycle = (cnt_q == SETTLE_C);
  assign mismatch   = (state_q == ST_DRIVE) && last_cycle && (y != FUNC[vec_q]);

  always_comb begin
    state_d         = state_q;
    vec_d           = vec_q;
    cnt_d           = cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_vec_d = first_err_vec_q;
    first_err_vld_d = first_err_vld_q;
`ifdef GATE_TESTER_LOOP_EN
    done_pulse_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d         = ST_DRIVE;
          vec_d           = 2'd0;
          cnt_d           = '0;
          err_cnt_d       = 3'd0;
          first_err_vec_d = 2'd0;
          first_err_vld_d = 1'b0;
        end
      end

      ST_DRIVE: begin
        if (last_cycle) begin
          cnt_d = '0;
          if (mismatch) begin
            if (err_cnt_q != 3'd7) err_cnt_d = err_cnt_q + 3'd1;
            if (!first_err_vld_q) begin
              first_err_vec_d = vec_q;
              first_err_vld_d = 1'b1;
            end
          end
          if (vec_q == 2'd3) begin
            vec_d = 2'd0;
`ifdef GATE_TESTER_LOOP_EN
            done_pulse_d = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef GATE_TESTER_LOOP_EN
        // stop overrides the sweep position but keeps the counts.
        if (stop) begin
          state_d      = ST_IDLE;
          vec_d        = 2'd0;
          cnt_d        = '0;
          done_pulse_d = 1'b0;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      vec_q           <= 2'd0;
      cnt_q           <= '0;
      err_cnt_q       <= 3'd0;
      first_err_vec_q <= 2'd0;
      first_err_vld_q <= 1'b0;
`ifdef GATE_TESTER_LOOP_EN
      done_pulse_q    <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      vec_q           <= vec_d;
      cnt_q           <= cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_vec_q <= first_err_vec_d;
      first_err_vld_q <= first_err_vld_d;
`ifdef GATE_TESTER_LOOP_EN
      done_pulse_q    <= done_pulse_d;
`endif
    end
  end

  // Gate inputs are forced to 00 outside DRIVE.
  assign a    = (state_q == ST_DRIVE) && vec_q[1];
  assign b    = (state_q == ST_DRIVE) && vec_q[0];
  assign busy = (state_q == ST_DRIVE);
`ifdef GATE_TESTER_LOOP_EN
  assign done = done_pulse_q;
`else
  assign done = (state_q == ST_DONE);
`endif
  assign pass          = done && (err_cnt_q == 3'd0);
  assign err_cnt       = err_cnt_q;
  assign first_err_vec = first_err_vec_q;
  assign first_err_vld = first_err_vld_q;

endmodule
